// File: rtl/aes_pkg.sv
// Shared types, widths and GF(2^8) helpers for the AES key-schedule engine.
// The S-box is computed from the field inverse plus affine map rather than a 256-entry table.
package aes_pkg;

    localparam int unsigned RK_W   = 128;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        KeyLen128 = 2'd0,
        KeyLen192 = 2'd1,
        KeyLen256 = 2'd2
    } key_len_e;

    typedef enum logic [1:0] {
        StIdle,
        StGen,
        StOut
    } state_e;

    // Mode 3 aliases AES-256; anything wider than the build supports falls back to the largest key.
    function automatic key_len_e clamp_len(input logic [1:0] key_len, input int unsigned max_bits);
        key_len_e len;
        case (key_len)
            2'd0:    len = KeyLen128;
            2'd1:    len = KeyLen192;
            default: len = KeyLen256;
        endcase
        if (max_bits < 192) begin
            len = KeyLen128;
        end else if ((max_bits < 256) && (len == KeyLen256)) begin
            len = KeyLen192;
        end
        return len;
    endfunction

    function automatic logic [3:0] nk_of(input key_len_e len);
        case (len)
            KeyLen128: return 4'd4;
            KeyLen192: return 4'd6;
            default:   return 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input key_len_e len);
        case (len)
            KeyLen128: return 4'd10;
            KeyLen192: return 4'd12;
            default:   return 4'd14;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                acc = acc ^ p;
            end
            p = xtime(p);
        end
        return acc;
    endfunction

    // b^254 is the multiplicative inverse (and maps 0 to 0), followed by the FIPS affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] inv;
        p   = b;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_key_word_step.sv
// One key-expansion step: w[i] = w[i-Nk] ^ f(w[i-1]), where f is identity, SubWord,
// or SubWord(RotWord) ^ rcon depending on the position within the Nk group.
module aes_key_word_step
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] prev_word,
    input  logic [WORD_W-1:0] oldest_word,
    input  logic [7:0]        rcon,
    input  logic              rot_sub,
    input  logic              sub_only,
    output logic [WORD_W-1:0] next_word
);

    logic [WORD_W-1:0] sbox_in;
    logic [WORD_W-1:0] sbox_out;
    logic [WORD_W-1:0] t;

    // Byte 0 of a word lives in the MSBs, so RotWord is a left rotate by one byte.
    assign sbox_in = rot_sub ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    sub_bytes #(
        .N_BYTES(4)
    ) u_sub_bytes (
        .data (sbox_in),
        .subst(sbox_out)
    );

    always_comb begin
        t = prev_word;
        if (rot_sub) begin
            t = sbox_out ^ {rcon, 24'h000000};
        end else if (sub_only) begin
            t = sbox_out;
        end
        next_word = oldest_word ^ t;
    end

endmodule

// File: rtl/sub_bytes.sv
// Parallel bank of AES S-boxes, one per input byte.
module sub_bytes
    import aes_pkg::*;
#(
    parameter int unsigned N_BYTES = 4
) (
    input  logic [8*N_BYTES-1:0] data,
    output logic [8*N_BYTES-1:0] subst
);

    for (genvar g = 0; g < N_BYTES; g++) begin : g_sbox
        assign subst[8*g +: 8] = sbox(data[8*g +: 8]);
    end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule: one schedule word per cycle, round keys handed
// out one at a time over a valid/yumi handshake.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int unsigned MAX_KEY_BITS_P = 256
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [255:0]    key_i,
    input  logic [1:0]      key_len_i,
    input  logic            v_i,
    output logic            ready_o,
    output logic [RK_W-1:0] rk_o,
    output logic [3:0]      rk_idx_o,
    output logic            rk_last_o,
    output logic            rk_v_o,
    input  logic            rk_yumi_i
);

    state_e                 state_q, state_d;
    logic [3:0]             nk_q, nk_d;
    logic [3:0]             nr_q, nr_d;
    logic [3:0]             idx_q, idx_d;
    logic [3:0]             wrap_q, wrap_d;
    logic [5:0]             word_q, word_d;
    logic [7:0]             rcon_q, rcon_d;
    logic [7:0][WORD_W-1:0] win_q, win_d;
    logic [3:0][WORD_W-1:0] rk_q, rk_d;

    key_len_e          len_sel;
    logic              expand;
    logic              rot_sub;
    logic              sub_only;
    logic [2:0]        last_slot;
    logic [WORD_W-1:0] new_word;
    logic [WORD_W-1:0] cur_word;

    assign len_sel   = clamp_len(key_len_i, MAX_KEY_BITS_P);
    assign expand    = word_q >= {2'b00, nk_q};
    assign rot_sub   = expand && (wrap_q == 4'd0);
    assign sub_only  = expand && (nk_q == 4'd8) && (wrap_q == 4'd4);
    assign last_slot = 3'(nk_q - 4'd1);

    // Window slot 0 always holds w[i-Nk] and slot Nk-1 holds w[i-1].
    aes_key_word_step u_step (
        .prev_word  (win_q[last_slot]),
        .oldest_word(win_q[0]),
        .rcon       (rcon_q),
        .rot_sub    (rot_sub),
        .sub_only   (sub_only),
        .next_word  (new_word)
    );

    assign cur_word = expand ? new_word : win_q[word_q[2:0]];

    always_comb begin
        state_d = state_q;
        nk_d    = nk_q;
        nr_d    = nr_q;
        idx_d   = idx_q;
        wrap_d  = wrap_q;
        word_d  = word_q;
        rcon_d  = rcon_q;
        win_d   = win_q;
        rk_d    = rk_q;
        case (state_q)
            StIdle: begin
                if (v_i) begin
                    nk_d   = nk_of(len_sel);
                    nr_d   = nr_of(len_sel);
                    for (int j = 0; j < 8; j++) begin
                        win_d[j] = key_i[32*j +: 32];
                    end
                    word_d  = 6'd0;
                    wrap_d  = 4'd0;
                    idx_d   = 4'd0;
                    rcon_d  = 8'h01;
                    state_d = StGen;
                end
            end
            StGen: begin
                rk_d[word_q[1:0]] = cur_word;
                if (expand) begin
                    for (int j = 0; j < 7; j++) begin
                        win_d[j] = win_q[j+1];
                    end
                    win_d[last_slot] = new_word;
                    if (rot_sub) begin
                        rcon_d = xtime(rcon_q);
                    end
                end
                word_d = word_q + 6'd1;
                wrap_d = (wrap_q == nk_q - 4'd1) ? 4'd0 : wrap_q + 4'd1;
                if (word_q[1:0] == 2'd3) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                if (rk_yumi_i) begin
                    if (idx_q == nr_q) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = StGen;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            nk_q    <= 4'd0;
            nr_q    <= 4'd0;
            idx_q   <= 4'd0;
            wrap_q  <= 4'd0;
            word_q  <= 6'd0;
            rcon_q  <= 8'h00;
            win_q   <= '0;
            rk_q    <= '0;
        end else begin
            state_q <= state_d;
            nk_q    <= nk_d;
            nr_q    <= nr_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            word_q  <= word_d;
            rcon_q  <= rcon_d;
            win_q   <= win_d;
            rk_q    <= rk_d;
        end
    end

    assign ready_o   = (state_q == StIdle);
    assign rk_v_o    = (state_q == StOut);
    assign rk_o      = rk_q;
    assign rk_idx_o  = idx_q;
    assign rk_last_o = (state_q == StOut) && (idx_q == nr_q);

endmodule
